// File: rtl/ser_pkg.sv
// Shared types and constants for the UART receive front end (ser_rcv).
package ser_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   localparam int DATA_BITS  = 8;
   localparam int BL_MIN     = 2;
   localparam int BL_DEFAULT = 5208;   // 9600 baud from a 50 MHz clock
endpackage

// File: rtl/ser_rcv_fifo.sv
// First-word-fall-through byte FIFO; push/pop take effect on the clock edge.
// Pop on empty is ignored; push on full is accepted only with a same-cycle pop.
module ser_rcv_fifo #(
   parameter int LOG2_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);
   localparam logic [LOG2_DEPTH:0] LAST_C  = (LOG2_DEPTH+1)'(DEPTH - 1);

   logic [LOG2_DEPTH:0] wr_ptr, rd_ptr, count;
   logic [7:0]          mem [DEPTH];
   logic                rd_en, wr_en;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr[LOG2_DEPTH-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[LOG2_DEPTH-1:0]] <= din;
            wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
         end
         if (rd_en)
            rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ser_rcv.sv
// UART receiver (8N1, or 8E1 with SER_RCV_PARITY_EN) feeding a FWFT byte FIFO; 2-cycle rxd sync,
// ready rises the cycle after the stop sample; bytes arriving with the FIFO full (and no read) are dropped and flagged.
module ser_rcv
   import ser_pkg::*;
#(
   parameter int LOG2_DEPTH = 2,
   parameter int BL_W       = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BL_W-1:0] bit_len,
   input  logic            read,
   output logic            ready,
   output logic [7:0]      data_out,
   output logic            ferr,
   output logic            ovr,
   input  logic            clr_err,
   input  logic            serial_in
`ifdef SER_RCV_PARITY_EN
   ,
   output logic            perr
`endif
);
   state_t          state;
   logic            sync1, rxd_s;
   logic [BL_W-1:0] cnt, len_eff, full_ld, half_ld;
   logic [2:0]      bitcnt;
   logic [7:0]      shreg;
   logic            tick, push, ferr_set, ovr_set, fifo_full, fifo_empty;

   assign len_eff  = (bit_len < BL_W'(BL_MIN)) ? BL_W'(BL_MIN) : bit_len;
   assign full_ld  = len_eff - 1'b1;
   assign half_ld  = (len_eff >> 1) - 1'b1;
   assign tick     = (cnt == '0);
   assign push     = (state == STOP) && tick && rxd_s;
   assign ferr_set = (state == STOP) && tick && !rxd_s;
   assign ovr_set  = push && fifo_full && !read;
   assign ready    = !fifo_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         sync1 <= serial_in;
         rxd_s <= sync1;
      end
   end

   // Counter free-runs down to zero; any load in the case below overrides the decrement.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         bitcnt <= '0;
         shreg  <= '0;
      end else begin
         if (!tick) cnt <= cnt - 1'b1;
         case (state)
            IDLE:
               if (!rxd_s) begin
                  cnt   <= half_ld;
                  state <= START;
               end
            START:
               if (tick) begin
                  if (rxd_s) begin
                     state <= IDLE;
                  end else begin
                     cnt    <= full_ld;
                     bitcnt <= '0;
                     state  <= DATA;
                  end
               end
            DATA:
               if (tick) begin
                  shreg  <= {rxd_s, shreg[7:1]};
                  bitcnt <= bitcnt + 1'b1;
                  cnt    <= full_ld;
                  if (bitcnt == 3'(DATA_BITS - 1))
`ifdef SER_RCV_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
               end
`ifdef SER_RCV_PARITY_EN
            PARITY:
               if (tick) begin
                  cnt   <= full_ld;
                  state <= STOP;
               end
`endif
            STOP:
               if (tick) state <= rxd_s ? IDLE : BRK;
            BRK:
               if (rxd_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky status flags: a set in the same cycle as clr_err wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ferr <= 1'b0;
         ovr  <= 1'b0;
      end else begin
         if (ferr_set)     ferr <= 1'b1;
         else if (clr_err) ferr <= 1'b0;
         if (ovr_set)      ovr  <= 1'b1;
         else if (clr_err) ovr  <= 1'b0;
      end
   end

`ifdef SER_RCV_PARITY_EN
   logic perr_set;
   assign perr_set = (state == PARITY) && tick && (^{shreg, rxd_s});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          perr <= 1'b0;
      else if (perr_set) perr <= 1'b1;
      else if (clr_err)  perr <= 1'b0;
   end
`endif

   ser_rcv_fifo #(.LOG2_DEPTH(LOG2_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (shreg),
      .pop   (read),
      .dout  (data_out),
      .empty (fifo_empty),
      .full  (fifo_full)
   );
endmodule

// File: tb/tb_ser_rcv.sv
// Bench for ser_rcv: frames driven on serial_in, checked against a queue model of the receive FIFO and flags.
module tb_ser_rcv;
   localparam int DEPTH = 4;
`ifdef SER_RCV_PARITY_EN
   localparam int NS = 11;
`else
   localparam int NS = 10;
`endif

   logic        clk = 1'b0, rst = 1'b0;
   logic [15:0] bit_len = 16'd16;
   logic        read = 1'b0, clr_err = 1'b0, serial_in = 1'b1;
   logic        ready, ferr, ovr;
   logic [7:0]  data_out;
`ifdef SER_RCV_PARITY_EN
   logic        perr;
`endif

   ser_rcv #(.LOG2_DEPTH(2), .BL_W(16)) dut (
      .clk(clk), .rst(rst), .bit_len(bit_len), .read(read), .ready(ready),
      .data_out(data_out), .ferr(ferr), .ovr(ovr), .clr_err(clr_err), .serial_in(serial_in)
`ifdef SER_RCV_PARITY_EN
      , .perr(perr)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   logic [7:0] exp_q[$];
   bit exp_ovr = 0, exp_ferr = 0, exp_perr = 0;
   int t0 = 0, rise_cyc = -1;
   logic ready_q = 1'b0;

   always @(negedge clk) begin
      if (ready && !ready_q) rise_cyc = cyc;
      ready_q = ready;
   end

   function automatic int eff_len();
      return (bit_len < 16'd2) ? 2 : int'(bit_len);
   endfunction

   function automatic int stop_edge();
      return 3 + (eff_len() >> 1) + (NS - 1) * eff_len();
   endfunction

   function automatic void model_push(input logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v, input int nslots);
      logic s [11];
      int L;
      L = eff_len();
      s[0] = 1'b0;
      for (int i = 0; i < 8; i++) s[i+1] = b[i];
`ifdef SER_RCV_PARITY_EN
      s[9] = par_v; s[10] = stop_v;
`else
      s[9] = stop_v; s[10] = par_v;
`endif
      for (int j = 0; j < nslots; j++) begin
         @(posedge clk); #1;
         if (j == 0) t0 = cyc;
         serial_in = s[j];
         repeat (L - 1) @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1 serial_in = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1, ^b, NS);
      idle(eff_len() + 6);
      model_push(b);
   endtask

   task automatic do_read(output logic r, output logic [7:0] d);
      @(negedge clk);
      r = ready; d = data_out;
      if (ready) begin
         read = 1'b1;
         @(posedge clk); #1 read = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr_err = 1'b1;
      @(posedge clk); #1 clr_err = 1'b0;
      exp_ferr = 0; exp_ovr = 0; exp_perr = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp += 4;
      if (ready !== 1'b0)     begin n_bad++; $display("FAIL reset_ready got %b want 0", ready); end
      if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", data_out); end
      if (ferr !== 1'b0)      begin n_bad++; $display("FAIL reset_ferr got %b want 0", ferr); end
      if (ovr !== 1'b0)       begin n_bad++; $display("FAIL reset_ovr got %b want 0", ovr); end
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_single();
      logic r; logic [7:0] d;
      bit_len = 16'd16;
      rise_cyc = -1;
      send_byte(8'h55);
      n_cmp++;
      if (rise_cyc - t0 !== stop_edge()) begin
         n_bad++; $display("FAIL single_latency got %0d want %0d", rise_cyc - t0, stop_edge());
      end
      do_read(r, d);
      n_cmp++;
      if (r !== 1'b1 || d !== exp_q[0]) begin n_bad++; $display("FAIL single_data got %b/%h want 1/%h", r, d, exp_q[0]); end
      void'(exp_q.pop_front());
      do_read(r, d);
      n_cmp++;
      if (r !== 1'b0) begin n_bad++; $display("FAIL single_empty ready got %b want 0", r); end
   endtask

   task automatic test_ferr_brk();
      logic r; logic [7:0] d;
      bit_len = 16'd16;
      send_frame(8'hA3, 1'b0, ^8'hA3, NS);
      repeat (3 * 16) @(posedge clk);
      exp_ferr = 1;
      @(negedge clk);
      n_cmp += 2;
      if (ferr !== exp_ferr) begin n_bad++; $display("FAIL brk_ferr got %b want %b", ferr, exp_ferr); end
      if (ready !== 1'b0)    begin n_bad++; $display("FAIL brk_ready got %b want 0", ready); end
      idle(22);
      send_byte(8'h3C);
      do_read(r, d);
      n_cmp += 2;
      if (r !== 1'b1 || d !== exp_q[0]) begin n_bad++; $display("FAIL brk_next got %b/%h want 1/%h", r, d, exp_q[0]); end
      void'(exp_q.pop_front());
      if (ferr !== exp_ferr) begin n_bad++; $display("FAIL brk_sticky got %b want %b", ferr, exp_ferr); end
      pulse_clr();
      @(negedge clk);
      n_cmp++;
      if (ferr !== exp_ferr) begin n_bad++; $display("FAIL brk_clr got %b want %b", ferr, exp_ferr); end
   endtask

   task automatic test_glitch();
      logic r; logic [7:0] d;
      bit_len = 16'd16;
      @(posedge clk); #1 serial_in = 1'b0;
      repeat (5) @(posedge clk); #1 serial_in = 1'b1;
      repeat (48) @(posedge clk);
      @(negedge clk);
      n_cmp += 2;
      if (ready !== 1'b0) begin n_bad++; $display("FAIL glitch_ready got %b want 0", ready); end
      if (ferr !== 1'b0)  begin n_bad++; $display("FAIL glitch_ferr got %b want 0", ferr); end
      send_byte(8'h5A);
      do_read(r, d);
      n_cmp++;
      if (r !== 1'b1 || d !== exp_q[0]) begin n_bad++; $display("FAIL glitch_after got %b/%h want 1/%h", r, d, exp_q[0]); end
      void'(exp_q.pop_front());
   endtask

   task automatic test_overrun();
      logic r; logic [7:0] d;
      bit_len = 16'd16;
      for (int i = 1; i <= 5; i++) send_byte(8'(i));
      @(negedge clk);
      n_cmp++;
      if (ovr !== exp_ovr) begin n_bad++; $display("FAIL ovr_set got %b want %b", ovr, exp_ovr); end
      for (int i = 0; i < 5; i++) begin
         do_read(r, d);
         n_cmp++;
         if (exp_q.size() == 0) begin
            if (r !== 1'b0) begin n_bad++; $display("FAIL ovr_drain%0d ready got %b want 0", i, r); end
         end else begin
            if (r !== 1'b1 || d !== exp_q[0]) begin n_bad++; $display("FAIL ovr_drain%0d got %b/%h want 1/%h", i, r, d, exp_q[0]); end
            void'(exp_q.pop_front());
         end
      end
      pulse_clr();
      @(negedge clk);
      n_cmp++;
      if (ovr !== exp_ovr) begin n_bad++; $display("FAIL ovr_clr got %b want %b", ovr, exp_ovr); end
   endtask

   task automatic test_full_coincident();
      logic r; logic [7:0] d;
      int e;
      bit_len = 16'd16;
      for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
      e = stop_edge();
      fork
         send_frame(8'h77, 1'b1, ^8'h77, NS);
         begin
            @(posedge clk); #2;
            repeat (e - 1) @(posedge clk);
            #1 read = 1'b1;
            @(posedge clk); #1 read = 1'b0;
         end
      join
      idle(22);
      void'(exp_q.pop_front());
      exp_q.push_back(8'h77);
      @(negedge clk);
      n_cmp++;
      if (ovr !== 1'b0) begin n_bad++; $display("FAIL coinc_ovr got %b want 0", ovr); end
      for (int i = 0; i < 5; i++) begin
         do_read(r, d);
         n_cmp++;
         if (exp_q.size() == 0) begin
            if (r !== 1'b0) begin n_bad++; $display("FAIL coinc_drain%0d ready got %b want 0", i, r); end
         end else begin
            if (r !== 1'b1 || d !== exp_q[0]) begin n_bad++; $display("FAIL coinc_drain%0d got %b/%h want 1/%h", i, r, d, exp_q[0]); end
            void'(exp_q.pop_front());
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic r; logic [7:0] d;
      bit_len = 16'd16;
      send_byte(8'($urandom));
      send_frame(8'hC6, 1'b1, 1'b0, 4);
      #1 rst = 1'b0;
      exp_q.delete(); exp_ovr = 0; exp_ferr = 0; exp_perr = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready got %b want 0", ready); end
      serial_in = 1'b1;
      #1 rst = 1'b1;
      idle(22);
`ifdef SER_RCV_PARITY_EN
      send_frame(8'h81, 1'b1, 1'b1, NS);
      idle(22);
      model_push(8'h81);
      exp_perr = 1;
      @(negedge clk);
      n_cmp++;
      if (perr !== exp_perr) begin n_bad++; $display("FAIL rstmid_perr got %b want %b", perr, exp_perr); end
`else
      send_byte(8'h81);
`endif
      for (int i = 0; i < 2; i++) begin
         do_read(r, d);
         n_cmp++;
         if (exp_q.size() == 0) begin
            if (r !== 1'b0) begin n_bad++; $display("FAIL rstmid_drain%0d ready got %b want 0", i, r); end
         end else begin
            if (r !== 1'b1 || d !== exp_q[0]) begin n_bad++; $display("FAIL rstmid_drain%0d got %b/%h want 1/%h", i, r, d, exp_q[0]); end
            void'(exp_q.pop_front());
         end
      end
      pulse_clr();
   endtask

   task automatic test_random();
      logic r; logic [7:0] d;
      logic [7:0] b;
      logic pv;
      int nrd;
      for (int it = 0; it < 14; it++) begin
         bit_len = 16'($urandom_range(0, 24));
         b = 8'($urandom);
         pv = (^b) ^ ($urandom_range(0, 3) == 0);
`ifdef SER_RCV_PARITY_EN
         if (pv != ^b) exp_perr = 1;
`endif
         if ($urandom_range(0, 4) == 0) begin
            send_frame(b, 1'b0, pv, NS);
            repeat (eff_len() * 2) @(posedge clk);
            idle(eff_len() + 6);
            exp_ferr = 1;
         end else begin
            send_frame(b, 1'b1, pv, NS);
            idle(eff_len() + 6);
            model_push(b);
         end
         nrd = $urandom_range(0, 2);
         for (int k = 0; k < nrd; k++) begin
            do_read(r, d);
            n_cmp++;
            if (exp_q.size() == 0) begin
               if (r !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_empty ready got %b want 0", it, r); end
            end else begin
               if (r !== 1'b1 || d !== exp_q[0]) begin n_bad++; $display("FAIL rnd%0d_data got %b/%h want 1/%h", it, r, d, exp_q[0]); end
               void'(exp_q.pop_front());
            end
         end
      end
      @(negedge clk);
      n_cmp += 2;
      if (ferr !== exp_ferr) begin n_bad++; $display("FAIL rnd_ferr got %b want %b", ferr, exp_ferr); end
      if (ovr !== exp_ovr)   begin n_bad++; $display("FAIL rnd_ovr got %b want %b", ovr, exp_ovr); end
`ifdef SER_RCV_PARITY_EN
      n_cmp++;
      if (perr !== exp_perr) begin n_bad++; $display("FAIL rnd_perr got %b want %b", perr, exp_perr); end
`endif
      while (exp_q.size() > 0) begin
         do_read(r, d);
         n_cmp++;
         if (r !== 1'b1 || d !== exp_q[0]) begin n_bad++; $display("FAIL rnd_drain got %b/%h want 1/%h", r, d, exp_q[0]); end
         void'(exp_q.pop_front());
      end
      do_read(r, d);
      n_cmp++;
      if (r !== 1'b0) begin n_bad++; $display("FAIL rnd_final ready got %b want 0", r); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ferr_brk();
      test_glitch();
      test_overrun();
      test_full_coincident();
      test_reset_midframe();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
